mmio_csr_bank: RTL and testbench
================================

MMIO_CSR_BANK -- requirements
Module: mmio_csr_bank

Interface
REQ-001 Parameter NUM_APP_CSRS, default 16: number of application CSRs (1..64).
REQ-002 Parameter NUM_CTRS, default 8: number of event counters (1..16).
REQ-003 Parameter CTR_WIDTH, default 48: counter width in bits (8..64).
REQ-004 Parameter CTR_SATURATE, default 0: 1 = counters saturate, 0 = counters wrap.
REQ-005 Parameter RSP_DEPTH, default 4: local read-response FIFO depth (power of 2, >=2).
REQ-006 Parameter [63:0] BLOCK_ID, default 0: value returned at CSR index 0.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 mmio_rd_valid / mmio_wr_valid  in  1 each  one-cycle MMIO read / write request strobes, mutually exclusive.
REQ-010 mmio_addr  in  16  dword address; CSR index = mmio_addr[15:1].
REQ-011 mmio_tid  in  9  request transaction ID; mmio_wr_data  in  64  write data.
REQ-012 fwd_rsp_valid, fwd_rsp_tid, fwd_rsp_data  in  1/9/64  read responses from downstream modules.
REQ-013 host_rsp_valid, host_rsp_tid, host_rsp_data  out  1/9/64  merged read responses toward host; no backpressure.
REQ-014 ctr_inc  in  NUM_CTRS  per-counter increment-by-one strobes.
REQ-015 app_wr_en  out  NUM_APP_CSRS  one-cycle write pulses; app_wr_data  out  64  fanned-out write data.
REQ-016 app_rd_data  in  NUM_APP_CSRS*64  application CSR read values.

Function
REQ-017 Local CSR map: 0 BLOCK_ID; 1 STATUS; 2 CONTROL; 8..8+NUM_CTRS-1 counters; 32..32+NUM_APP_CSRS-1 application CSRs; any other index is non-local.
REQ-018 STATUS = {overflow_sticky[63], 55'b0, fifo_count[7:0]}; CONTROL reads as 0.
REQ-019 Reads of non-local indices produce no local response; non-local writes are ignored.
REQ-020 Local read: data sampled in the request cycle +1 and pushed into the response FIFO with the request tid.
REQ-021 Merge: if fwd_rsp_valid, host_rsp carries the forwarded response that cycle, registered (1-cycle latency); else the FIFO head pops onto host_rsp.
REQ-022 Uncontended local read latency: exactly 2 cycles from mmio_rd_valid to host_rsp_valid.
REQ-023 Responses from the FIFO are issued in request order; forwarded responses are never dropped or delayed.
REQ-024 FIFO full on push: the new response is dropped and overflow_sticky sets; it clears only on reset or a CONTROL bit 2 write.
REQ-025 App write to index 32+i: app_wr_en[i]=1 exactly one cycle later; app_wr_data valid in the same cycle.
REQ-026 Counters: +1 per cycle with ctr_inc[k]=1; at all-ones, wrap to 0 (CTR_SATURATE=0) or hold (=1); values zero-extended to 64 bits on read.
REQ-027 CONTROL write bit 0=1 clears all counters next cycle; an increment in the same cycle is lost (clear wins).
REQ-028 A counter read in the same cycle as an increment returns the pre-increment value.

Reset
REQ-029 On reset: host_rsp_valid=0, host_rsp_tid=0, host_rsp_data=0, app_wr_en=0, app_wr_data=0, FIFO empty, counters=0, overflow_sticky=0.
REQ-030 Reset mid-operation discards all queued local responses; no response is issued in the cycle after reset deasserts.

Configuration
REQ-031 Macro MMIO_CSR_BANK_SNAPSHOT_EN defined: CONTROL bit 1 write copies all counters atomically into snapshot registers next cycle; counter-index reads return the snapshot; snapshots reset to 0.
REQ-032 Macro absent: no snapshot registers, CONTROL bit 1 ignored, counter reads return live values.

Verification
REQ-033 Read index 0, BLOCK_ID=64'hA5, tid 0x12 -> host_rsp_valid 2 cycles later, data 0xA5, tid 0x12.
REQ-034 Local read at cycle T with fwd_rsp_valid at T+1 and T+2 -> forwarded responses at T+2 and T+3, local at T+4.
REQ-035 Five local reads with RSP_DEPTH=4 while fwd_rsp_valid held high -> fifth dropped, STATUS[63]=1, four responses in order after fwd stops.
REQ-036 CTR_WIDTH=8, CTR_SATURATE=0, 257 increments on ctr 0 -> read index 8 returns 1; with CTR_SATURATE=1 -> 255.
REQ-037 Write 64'h1234 to index 33 -> app_wr_en[1] high exactly one cycle, app_wr_data=0x1234, all other enables 0.
REQ-038 With MMIO_CSR_BANK_SNAPSHOT_EN: counter at 10, snapshot, 5 more increments -> read returns 10; without the macro -> 15.

Source files
------------

// File: rtl/mmio_csr_bank_if.sv
//==============================================================================
// Module  : mmio_csr_bank_if
// Brief   : MMIO request, forwarded-response and host-response bundle for
//           mmio_csr_bank.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface mmio_csr_bank_if;
    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;

    logic        fwd_rsp_valid;
    logic [8:0]  fwd_rsp_tid;
    logic [63:0] fwd_rsp_data;

    logic        host_rsp_valid;
    logic [8:0]  host_rsp_tid;
    logic [63:0] host_rsp_data;

    modport master (
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wr_data,
        output fwd_rsp_valid, fwd_rsp_tid, fwd_rsp_data,
        input  host_rsp_valid, host_rsp_tid, host_rsp_data
    );

    modport slave (
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wr_data,
        input  fwd_rsp_valid, fwd_rsp_tid, fwd_rsp_data,
        output host_rsp_valid, host_rsp_tid, host_rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/mmio_csr_bank.sv
//==============================================================================
// Module  : mmio_csr_bank
// Brief   : Local MMIO CSR bank (ID, status, control, event counters, app CSRs)
//           merging local read responses with forwarded downstream responses.
//           Optional counter snapshots: define MMIO_CSR_BANK_SNAPSHOT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mmio_csr_bank #(
    parameter int          NUM_APP_CSRS = 16,
    parameter int          NUM_CTRS     = 8,
    parameter int          CTR_WIDTH    = 48,
    parameter int          CTR_SATURATE = 0,
    parameter int          RSP_DEPTH    = 4,
    parameter logic [63:0] BLOCK_ID     = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    mmio_csr_bank_if.slave             bus,
    input  logic [NUM_CTRS-1:0]        ctr_inc_i,
    output logic [NUM_APP_CSRS-1:0]    app_wr_en_o,
    output logic [63:0]                app_wr_data_o,
    input  logic [NUM_APP_CSRS*64-1:0] app_rd_data_i
);

    localparam int                   PTR_W        = $clog2(RSP_DEPTH);
    localparam int                   CNT_W        = PTR_W + 1;
    localparam logic [14:0]          IDX_BLOCK_ID = 15'd0;
    localparam logic [14:0]          IDX_STATUS   = 15'd1;
    localparam logic [14:0]          IDX_CONTROL  = 15'd2;
    localparam int                   IDX_CTR_BASE = 8;
    localparam int                   IDX_APP_BASE = 32;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX      = '1;
    localparam logic [CNT_W-1:0]     FIFO_FULL    = CNT_W'(RSP_DEPTH);

    logic [14:0]             idx;
    logic                    is_blk, is_status, is_ctrl, is_local;
    logic [NUM_CTRS-1:0]     ctr_hit;
    logic [NUM_APP_CSRS-1:0] app_hit;
    logic [63:0]             rd_data;
    logic                    ctrl_wr, clr_ctrs, ovf_clr;
    logic                    unused_addr_lsb;

    logic [CTR_WIDTH-1:0]    ctr_q    [NUM_CTRS];
    logic [CTR_WIDTH-1:0]    ctr_d    [NUM_CTRS];
    logic [CTR_WIDTH-1:0]    ctr_view [NUM_CTRS];

    logic [8:0]              tid_mem_q  [RSP_DEPTH];
    logic [63:0]             data_mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    push_req, push, pop, drop;
    logic                    ovf_q;

    logic                    rsp_valid_q;
    logic [8:0]              rsp_tid_q;
    logic [63:0]             rsp_data_q;
    logic [NUM_APP_CSRS-1:0] app_wr_en_q;
    logic [63:0]             app_wr_data_q;

    assign idx             = bus.mmio_addr[15:1];
    assign unused_addr_lsb = bus.mmio_addr[0];

    assign is_blk    = (idx == IDX_BLOCK_ID);
    assign is_status = (idx == IDX_STATUS);
    assign is_ctrl   = (idx == IDX_CONTROL);

    always_comb begin
        ctr_hit = '0;
        app_hit = '0;
        for (int k = 0; k < NUM_CTRS; k++)
            ctr_hit[k] = (idx == 15'(IDX_CTR_BASE + k));
        for (int i = 0; i < NUM_APP_CSRS; i++)
            app_hit[i] = (idx == 15'(IDX_APP_BASE + i));
    end

    assign is_local = is_blk | is_status | is_ctrl | (|ctr_hit) | (|app_hit);

    // Read data is taken from pre-edge state, so a same-cycle increment is not visible.
    always_comb begin
        rd_data = 64'd0;
        if (is_blk)
            rd_data = BLOCK_ID;
        if (is_status)
            rd_data = {ovf_q, 55'd0, 8'(count_q)};
        for (int k = 0; k < NUM_CTRS; k++)
            if (ctr_hit[k])
                rd_data = 64'(ctr_view[k]);
        for (int i = 0; i < NUM_APP_CSRS; i++)
            if (app_hit[i])
                rd_data = app_rd_data_i[i*64 +: 64];
    end

    assign ctrl_wr  = bus.mmio_wr_valid && is_ctrl;
    assign clr_ctrs = ctrl_wr && bus.mmio_wr_data[0];
    assign ovf_clr  = ctrl_wr && bus.mmio_wr_data[2];

    always_comb begin
        for (int k = 0; k < NUM_CTRS; k++) begin
            ctr_d[k] = ctr_q[k];
            if (clr_ctrs)
                ctr_d[k] = '0;
            else if (ctr_inc_i[k] && !(CTR_SATURATE != 0 && ctr_q[k] == CTR_MAX))
                ctr_d[k] = ctr_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CTRS; k++)
                ctr_q[k] <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

`ifdef MMIO_CSR_BANK_SNAPSHOT_EN
    logic                 snap_req;
    logic [CTR_WIDTH-1:0] snap_q [NUM_CTRS];

    assign snap_req = ctrl_wr && bus.mmio_wr_data[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CTRS; k++)
                snap_q[k] <= '0;
        end else if (snap_req) begin
            snap_q <= ctr_q;
        end
    end

    assign ctr_view = snap_q;
`else
    assign ctr_view = ctr_q;
`endif

    // A pop in the same cycle frees a slot, so a push onto a full FIFO then succeeds.
    assign pop      = !bus.fwd_rsp_valid && (count_q != '0);
    assign push_req = bus.mmio_rd_valid && is_local;
    assign push     = push_req && ((count_q != FIFO_FULL) || pop);
    assign drop     = push_req && !push;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tid_mem_q[wr_ptr_q]  <= bus.mmio_tid;
            data_mem_q[wr_ptr_q] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // Forwarded responses always take the host slot; local ones wait in the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else if (bus.fwd_rsp_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_tid_q   <= bus.fwd_rsp_tid;
            rsp_data_q  <= bus.fwd_rsp_data;
        end else if (pop) begin
            rsp_valid_q <= 1'b1;
            rsp_tid_q   <= tid_mem_q[rd_ptr_q];
            rsp_data_q  <= data_mem_q[rd_ptr_q];
        end else begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            app_wr_en_q   <= '0;
            app_wr_data_q <= '0;
        end else begin
            app_wr_en_q <= bus.mmio_wr_valid ? app_hit : '0;
            if (bus.mmio_wr_valid && (|app_hit))
                app_wr_data_q <= bus.mmio_wr_data;
        end
    end

    assign bus.host_rsp_valid = rsp_valid_q;
    assign bus.host_rsp_tid   = rsp_tid_q;
    assign bus.host_rsp_data  = rsp_data_q;
    assign app_wr_en_o        = app_wr_en_q;
    assign app_wr_data_o      = app_wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_csr_bank.sv
//==============================================================================
// Module  : tb_mmio_csr_bank
// Brief   : Self-checking bench for mmio_csr_bank (wrapping and saturating
//           instances) against a queue-based behavioural model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mmio_csr_bank;
    localparam int NA    = 4;
    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     ctr_inc;
    logic [NA*64-1:0]  app_rd_data;
    logic [NA-1:0]     app_wr_en, app_wr_en_s;
    logic [63:0]       app_wr_data, app_wr_data_s;

    mmio_csr_bank_if bus ();
    mmio_csr_bank_if bus_s ();

    assign bus_s.mmio_rd_valid = bus.mmio_rd_valid;
    assign bus_s.mmio_wr_valid = bus.mmio_wr_valid;
    assign bus_s.mmio_addr     = bus.mmio_addr;
    assign bus_s.mmio_tid      = bus.mmio_tid;
    assign bus_s.mmio_wr_data  = bus.mmio_wr_data;
    assign bus_s.fwd_rsp_valid = bus.fwd_rsp_valid;
    assign bus_s.fwd_rsp_tid   = bus.fwd_rsp_tid;
    assign bus_s.fwd_rsp_data  = bus.fwd_rsp_data;

    mmio_csr_bank #(
        .NUM_APP_CSRS(NA), .NUM_CTRS(NC), .CTR_WIDTH(8), .CTR_SATURATE(0),
        .RSP_DEPTH(DEPTH), .BLOCK_ID(64'hA5)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .ctr_inc_i(ctr_inc),
        .app_wr_en_o(app_wr_en), .app_wr_data_o(app_wr_data), .app_rd_data_i(app_rd_data)
    );

    mmio_csr_bank #(
        .NUM_APP_CSRS(NA), .NUM_CTRS(NC), .CTR_WIDTH(8), .CTR_SATURATE(1),
        .RSP_DEPTH(DEPTH), .BLOCK_ID(64'hA5)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s), .ctr_inc_i(ctr_inc),
        .app_wr_en_o(app_wr_en_s), .app_wr_data_o(app_wr_data_s), .app_rd_data_i(app_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the wrapping instance
    typedef struct packed { logic [8:0] tid; logic [63:0] data; } rsp_t;
    rsp_t          m_q[$];
    int            m_ctr  [NC];
    int            m_snap [NC];
    bit            m_ovf;
    bit            exp_valid;
    logic [8:0]    exp_tid;
    logic [63:0]   exp_data;
    logic [NA-1:0] exp_en;
    logic [63:0]   exp_wdata;

    function automatic logic [63:0] model_read(input int idx, output bit loc);
        loc = 1'b1;
        if (idx == 0) return 64'hA5;
        if (idx == 1) return {m_ovf, 55'd0, 8'(m_q.size())};
        if (idx == 2) return 64'd0;
        if (idx >= 8 && idx < 8 + NC) begin
`ifdef MMIO_CSR_BANK_SNAPSHOT_EN
            return 64'(m_snap[idx-8]);
`else
            return 64'(m_ctr[idx-8]);
`endif
        end
        if (idx >= 32 && idx < 32 + NA) return app_rd_data[(idx-32)*64 +: 64];
        loc = 1'b0;
        return 64'd0;
    endfunction

    task automatic set_idle();
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_addr     = '0;
        bus.mmio_tid      = '0;
        bus.mmio_wr_data  = '0;
        bus.fwd_rsp_valid = 1'b0;
        bus.fwd_rsp_tid   = '0;
        bus.fwd_rsp_data  = '0;
        ctr_inc           = '0;
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < NC; k++) begin
            m_ctr[k]  = 0;
            m_snap[k] = 0;
        end
        m_ovf     = 1'b0;
        exp_valid = 1'b0;
        exp_tid   = '0;
        exp_data  = '0;
        exp_en    = '0;
        exp_wdata = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of stimulus, advance the model, and stop 1 time unit after the edge.
    task automatic tick(input bit rd, input bit wr, input int idx, input logic [8:0] tid,
                        input logic [63:0] wd, input bit fv, input logic [8:0] ft,
                        input logic [63:0] fd, input logic [NC-1:0] inc);
        bit          loc;
        logic [63:0] rdv;
        rsp_t        r;
        bit          ctl;
        bus.mmio_rd_valid = rd;
        bus.mmio_wr_valid = wr;
        bus.mmio_addr     = {idx[14:0], 1'b0};
        bus.mmio_tid      = tid;
        bus.mmio_wr_data  = wd;
        bus.fwd_rsp_valid = fv;
        bus.fwd_rsp_tid   = ft;
        bus.fwd_rsp_data  = fd;
        ctr_inc           = inc;

        rdv = model_read(idx, loc);
        if (fv) begin
            exp_valid = 1'b1; exp_tid = ft; exp_data = fd;
        end else if (m_q.size() > 0) begin
            r = m_q.pop_front();
            exp_valid = 1'b1; exp_tid = r.tid; exp_data = r.data;
        end else begin
            exp_valid = 1'b0;
        end
        if (rd && loc) begin
            if (m_q.size() < DEPTH) m_q.push_back({tid, rdv});
            else m_ovf = 1'b1;
        end
        exp_en = '0;
        if (wr && idx >= 32 && idx < 32 + NA) begin
            exp_en[idx-32] = 1'b1;
            exp_wdata      = wd;
        end
        ctl = wr && (idx == 2);
        if (ctl && wd[2]) m_ovf = 1'b0;
`ifdef MMIO_CSR_BANK_SNAPSHOT_EN
        if (ctl && wd[1]) m_snap = m_ctr;
`endif
        for (int k = 0; k < NC; k++) begin
            if (ctl && wd[0]) m_ctr[k] = 0;
            else if (inc[k])  m_ctr[k] = (m_ctr[k] + 1) % 256;
        end

        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic idle_tick();
        tick(0, 0, 0, 9'd0, 64'd0, 0, 9'd0, 64'd0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (bus.host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.host_rsp_valid); end
        if (bus.host_rsp_tid !== 9'd0) begin n_bad++; $display("FAIL reset_tid got %0h want 0", bus.host_rsp_tid); end
        if (bus.host_rsp_data !== 64'd0) begin n_bad++; $display("FAIL reset_data got %0h want 0", bus.host_rsp_data); end
        if (app_wr_en !== '0) begin n_bad++; $display("FAIL reset_app_en got %0b want 0", app_wr_en); end
        if (app_wr_data !== 64'd0) begin n_bad++; $display("FAIL reset_app_data got %0h want 0", app_wr_data); end
        tick(1, 0, 1, 9'h3, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'd0) begin
            n_bad++; $display("FAIL reset_status got v=%0b d=%0h want v=1 d=0", bus.host_rsp_valid, bus.host_rsp_data);
        end
    endtask

    task automatic test_block_id();
        do_reset();
        tick(1, 0, 0, 9'h12, 64'd0, 0, 9'd0, 64'd0, '0);
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL blkid_early got %0b want 0", bus.host_rsp_valid); end
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_tid !== 9'h12 || bus.host_rsp_data !== 64'hA5) begin
            n_bad++; $display("FAIL blkid_rsp got v=%0b tid=%0h d=%0h want v=1 tid=12 d=a5",
                              bus.host_rsp_valid, bus.host_rsp_tid, bus.host_rsp_data);
        end
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL blkid_once got %0b want 0", bus.host_rsp_valid); end
    endtask

    task automatic test_fwd_merge();
        logic [8:0]  want_tid [3] = '{9'h101, 9'h102, 9'h33};
        logic [63:0] want_dat [3] = '{64'hF1, 64'hF2, 64'hA5};
        do_reset();
        tick(1, 0, 0, 9'h33, 64'd0, 0, 9'd0, 64'd0, '0);
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL merge_t1 got %0b want 0", bus.host_rsp_valid); end
        tick(0, 0, 0, 9'd0, 64'd0, 1, 9'h101, 64'hF1, '0);
        for (int s = 0; s < 3; s++) begin
            if (s == 1) tick(0, 0, 0, 9'd0, 64'd0, 1, 9'h102, 64'hF2, '0);
            if (s == 2) idle_tick();
            n_cmp++;
            if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_tid !== want_tid[s] || bus.host_rsp_data !== want_dat[s]) begin
                n_bad++; $display("FAIL merge_slot%0d got v=%0b tid=%0h d=%0h want v=1 tid=%0h d=%0h", s,
                                  bus.host_rsp_valid, bus.host_rsp_tid, bus.host_rsp_data, want_tid[s], want_dat[s]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick(i <= 5, 0, 0, 9'(i), 64'd0, 1, 9'(9'h1F0 + i), 64'(i), '0);
            n_cmp++;
            if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_tid !== 9'(9'h1F0 + i)) begin
                n_bad++; $display("FAIL ovf_fwd%0d got v=%0b tid=%0h want v=1 tid=%0h", i,
                                  bus.host_rsp_valid, bus.host_rsp_tid, 9'(9'h1F0 + i));
            end
        end
        for (int i = 1; i <= 5; i++) begin
            idle_tick();
            n_cmp++;
            if (i <= 4) begin
                if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_tid !== 9'(i) || bus.host_rsp_data !== 64'hA5) begin
                    n_bad++; $display("FAIL ovf_order%0d got v=%0b tid=%0h want v=1 tid=%0h", i,
                                      bus.host_rsp_valid, bus.host_rsp_tid, i);
                end
            end else if (bus.host_rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL ovf_extra got v=%0b tid=%0h want v=0", bus.host_rsp_valid, bus.host_rsp_tid);
            end
        end
        tick(1, 0, 1, 9'h7, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'h8000_0000_0000_0000) begin
            n_bad++; $display("FAIL ovf_sticky got v=%0b d=%0h want v=1 d=8000000000000000", bus.host_rsp_valid, bus.host_rsp_data);
        end
        tick(0, 1, 2, 9'd0, 64'h4, 0, 9'd0, 64'd0, '0);
        tick(1, 0, 1, 9'h8, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'd0) begin
            n_bad++; $display("FAIL ovf_clear got v=%0b d=%0h want v=1 d=0", bus.host_rsp_valid, bus.host_rsp_data);
        end
    endtask

    task automatic test_ctr_wrap();
        do_reset();
        repeat (257) tick(0, 0, 0, 9'd0, 64'd0, 0, 9'd0, 64'd0, 4'b0001);
        tick(1, 0, 8, 9'h21, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp += 2;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'd1) begin
            n_bad++; $display("FAIL ctr_wrap got v=%0b d=%0h want v=1 d=1", bus.host_rsp_valid, bus.host_rsp_data);
        end
        if (bus_s.host_rsp_valid !== 1'b1 || bus_s.host_rsp_data !== 64'd255) begin
            n_bad++; $display("FAIL ctr_sat got v=%0b d=%0h want v=1 d=ff", bus_s.host_rsp_valid, bus_s.host_rsp_data);
        end
        // Clear wins over an increment in the same cycle; a same-cycle read sees the old value.
        repeat (3) tick(0, 0, 0, 9'd0, 64'd0, 0, 9'd0, 64'd0, 4'b0010);
        tick(1, 0, 9, 9'h22, 64'd0, 0, 9'd0, 64'd0, 4'b0010);
        tick(0, 1, 2, 9'd0, 64'h1, 0, 9'd0, 64'd0, 4'b0010);
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'd3) begin
            n_bad++; $display("FAIL ctr_preinc got v=%0b d=%0h want v=1 d=3", bus.host_rsp_valid, bus.host_rsp_data);
        end
        tick(1, 0, 9, 9'h23, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== 64'd0) begin
            n_bad++; $display("FAIL ctr_clear got v=%0b d=%0h want v=1 d=0", bus.host_rsp_valid, bus.host_rsp_data);
        end
    endtask

    task automatic test_app_write();
        do_reset();
        tick(0, 1, 33, 9'd0, 64'h1234, 0, 9'd0, 64'd0, '0);
        n_cmp += 2;
        if (app_wr_en !== 4'b0010) begin n_bad++; $display("FAIL app_en got %0b want 0010", app_wr_en); end
        if (app_wr_data !== 64'h1234) begin n_bad++; $display("FAIL app_data got %0h want 1234", app_wr_data); end
        idle_tick();
        n_cmp++;
        if (app_wr_en !== 4'b0000) begin n_bad++; $display("FAIL app_en_pulse got %0b want 0000", app_wr_en); end
        tick(0, 1, 40, 9'd0, 64'hBEEF, 0, 9'd0, 64'd0, '0);
        n_cmp++;
        if (app_wr_en !== 4'b0000 || app_wr_data !== 64'h1234) begin
            n_bad++; $display("FAIL app_nonlocal got en=%0b d=%0h want en=0000 d=1234", app_wr_en, app_wr_data);
        end
    endtask

    task automatic test_snapshot();
        logic [63:0] want;
`ifdef MMIO_CSR_BANK_SNAPSHOT_EN
        want = 64'd10;
`else
        want = 64'd15;
`endif
        do_reset();
        repeat (10) tick(0, 0, 0, 9'd0, 64'd0, 0, 9'd0, 64'd0, 4'b0010);
        tick(0, 1, 2, 9'd0, 64'h2, 0, 9'd0, 64'd0, '0);
        repeat (5) tick(0, 0, 0, 9'd0, 64'd0, 0, 9'd0, 64'd0, 4'b0010);
        tick(1, 0, 9, 9'h44, 64'd0, 0, 9'd0, 64'd0, '0);
        idle_tick();
        n_cmp++;
        if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_data !== want) begin
            n_bad++; $display("FAIL snapshot got v=%0b d=%0h want v=1 d=%0h", bus.host_rsp_valid, bus.host_rsp_data, want);
        end
    endtask

    task automatic test_random();
        int idx_pool [14] = '{0, 1, 2, 3, 8, 9, 10, 11, 12, 32, 33, 34, 35, 36};
        int idx, op;
        bit rd, wr, fv;
        logic [63:0] wd;
        do_reset();
        for (int i = 0; i < NA; i++)
            app_rd_data[i*64 +: 64] = {$urandom(), $urandom()};
        for (int c = 0; c < 600; c++) begin
            op  = $urandom_range(0, 9);
            rd  = (op < 4);
            wr  = (op == 4 || op == 5);
            idx = ($urandom_range(0, 15) == 0) ? $urandom_range(64, 32767) : idx_pool[$urandom_range(0, 13)];
            wd  = {$urandom(), $urandom()};
            if (wr && idx == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            fv  = ($urandom_range(0, 9) < 4);
            tick(rd, wr, idx, 9'($urandom()), wd, fv, 9'($urandom()), {$urandom(), $urandom()}, NC'($urandom()));
            n_cmp++;
            if (bus.host_rsp_valid !== exp_valid) begin
                n_bad++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, bus.host_rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++;
                if (bus.host_rsp_tid !== exp_tid || bus.host_rsp_data !== exp_data) begin
                    n_bad++; $display("FAIL rnd_rsp c=%0d got tid=%0h d=%0h want tid=%0h d=%0h",
                                      c, bus.host_rsp_tid, bus.host_rsp_data, exp_tid, exp_data);
                end
            end
            n_cmp++;
            if (app_wr_en !== exp_en || app_wr_data !== exp_wdata) begin
                n_bad++; $display("FAIL rnd_app c=%0d got en=%0b d=%0h want en=%0b d=%0h",
                                  c, app_wr_en, app_wr_data, exp_en, exp_wdata);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 3; i++)
            tick(1, 0, 0, 9'(i + 1), 64'd0, 1, 9'h100, 64'd0, '0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            n_cmp++;
            if (bus.host_rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL midreset_rsp%0d got v=%0b tid=%0h want v=0", i, bus.host_rsp_valid, bus.host_rsp_tid);
            end
        end
    endtask

    initial begin
        set_idle();
        app_rd_data = '0;
        reset = 1'b1;
        model_reset();
        test_reset();
        test_block_id();
        test_fwd_merge();
        test_overflow();
        test_ctr_wrap();
        test_app_write();
        test_snapshot();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
